// File: rtl/crypto_pkg.sv
// Shared definitions for the block-cipher stream engines: modes, FSM encoding,
// block layout and the Feistel round primitives.
package crypto_pkg;

   localparam int unsigned BLOCK_SIZE = 64;
   localparam int unsigned KEY_SIZE   = 64;
   localparam int unsigned HALF_W     = BLOCK_SIZE / 2;

   localparam logic [1:0] MODE_ECB     = 2'b00;
   localparam logic [1:0] MODE_CBC     = 2'b01;
   localparam logic [1:0] MODE_CTR     = 2'b10;
   localparam logic [1:0] MODE_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CORE,
      ST_OUT,
      ST_FIN,
      ST_ERR
   } state_e;

   typedef logic [HALF_W-1:0] half_t;

   typedef struct packed {
      half_t l;
      half_t r;
   } block_t;

   // Even rounds use the upper key half, odd rounds the lower, salted with the index.
   function automatic half_t round_key(input logic [KEY_SIZE-1:0] key, input int unsigned idx);
      half_t base;
      base = idx[0] ? key[HALF_W-1:0] : key[KEY_SIZE-1:HALF_W];
      return base ^ HALF_W'(idx);
   endfunction

   function automatic half_t f_round(input half_t x, input half_t k);
      return {x[HALF_W-4:0], x[HALF_W-1:HALF_W-3]} ^ (x + k);
   endfunction

endpackage

// File: rtl/crypto_decrypt_stream_if.sv
// Ciphertext-in / plaintext-out stream handshake bundle.
interface crypto_decrypt_stream_if;

   logic                             ct_valid;
   logic                             ct_ready;
   logic [crypto_pkg::BLOCK_SIZE-1:0] ct_data;
   logic                             pt_valid;
   logic                             pt_ready;
   logic [crypto_pkg::BLOCK_SIZE-1:0] pt_data;
   logic                             pt_last;

   modport slave (
      input  ct_valid, ct_data, pt_ready,
      output ct_ready, pt_valid, pt_data, pt_last
   );

   modport master (
      output ct_valid, ct_data, pt_ready,
      input  ct_ready, pt_valid, pt_data, pt_last
   );

endinterface

// File: rtl/feistel_core.sv
// Iterated Feistel core, one round per clock in either direction.
// dout/done present the round being committed this cycle, so the caller can
// register the finished block on the same edge as the final round.
module feistel_core
   import crypto_pkg::*;
#(
   parameter int unsigned ROUNDS = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  dir,
   input  logic [KEY_SIZE-1:0]   key,
   input  logic [BLOCK_SIZE-1:0] din,
   output logic [BLOCK_SIZE-1:0] dout,
   output logic                  done
);

   localparam int unsigned RW = $clog2(ROUNDS + 1);

   logic          run_q, run_d;
   logic [RW-1:0] rnd_q, rnd_d;
   block_t        blk_q, blk_d;
   int unsigned   kidx;
   half_t         rk;
   half_t         fv;

   always_comb begin
      run_d = run_q;
      rnd_d = rnd_q;
      blk_d = blk_q;

      // Decryption walks the key schedule backwards.
      kidx = dir ? (ROUNDS - 1 - 32'(rnd_q)) : 32'(rnd_q);
      rk   = round_key(key, kidx);
      fv   = f_round(dir ? blk_q.l : blk_q.r, rk);
      dout = dir ? {blk_q.r ^ fv, blk_q.l} : {blk_q.r, blk_q.l ^ fv};
      done = run_q && (rnd_q == RW'(ROUNDS - 1));

      if (start) begin
         run_d = 1'b1;
         rnd_d = '0;
         blk_d = din;
      end else if (run_q) begin
         blk_d = dout;
         rnd_d = rnd_q + RW'(1);
         if (done) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_q <= 1'b0;
         rnd_q <= '0;
         blk_q <= '0;
      end else begin
         run_q <= run_d;
         rnd_q <= rnd_d;
         blk_q <= blk_d;
      end
   end

endmodule

// File: rtl/crypto_decrypt_stream.sv
// Streaming ECB/CBC/CTR decryptor: one 64-bit block per handshake through a
// shared iterated Feistel core, with chaining and counter handling around it.
module crypto_decrypt_stream
   import crypto_pkg::*;
#(
   parameter int unsigned ROUNDS = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [1:0]             mode,
   input  logic [KEY_SIZE-1:0]    key,
   input  logic [BLOCK_SIZE-1:0]  iv_nonce,
   input  logic [CNT_W-1:0]       num_blocks,
   crypto_decrypt_stream_if.slave s,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   state_e                  state_q, state_d;
   logic [1:0]              mode_q, mode_d;
   logic [KEY_SIZE-1:0]     key_q, key_d;
   logic [BLOCK_SIZE-1:0]   chain_q, chain_d;
   logic [BLOCK_SIZE-1:0]   ctr_q, ctr_d;
   logic [BLOCK_SIZE-1:0]   ct_q, ct_d;
   logic [CNT_W-1:0]        nblk_q, nblk_d;
   logic [CNT_W-1:0]        blk_q, blk_d;
   logic [BLOCK_SIZE-1:0]   pt_data_q, pt_data_d;
   logic                    pt_last_q, pt_last_d;
   logic                    pt_valid_q, pt_valid_d;
   logic                    ct_ready_q, ct_ready_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;

   logic                    core_start_c;
   logic                    core_done_c;
   logic [BLOCK_SIZE-1:0]   core_din_c;
   logic [BLOCK_SIZE-1:0]   core_dout_c;
   logic                    is_last_c;

   // CTR runs the core forward on the counter; ECB/CBC run it backward on the ciphertext.
   assign core_din_c = (mode_q == MODE_CTR) ? ctr_q : s.ct_data;
   assign is_last_c  = (blk_q == nblk_q - CNT_W'(1));

   feistel_core #(.ROUNDS(ROUNDS)) u_core (
      .clk   (clk),
      .reset (reset),
      .start (core_start_c),
      .dir   (mode_q != MODE_CTR),
      .key   (key_q),
      .din   (core_din_c),
      .dout  (core_dout_c),
      .done  (core_done_c)
   );

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      key_d        = key_q;
      chain_d      = chain_q;
      ctr_d        = ctr_q;
      ct_d         = ct_q;
      nblk_d       = nblk_q;
      blk_d        = blk_q;
      pt_data_d    = pt_data_q;
      core_start_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (mode == MODE_ILLEGAL || num_blocks == '0) begin
                  state_d = ST_ERR;
               end else begin
                  mode_d  = mode;
                  key_d   = key;
                  nblk_d  = num_blocks;
                  chain_d = iv_nonce;
                  ctr_d   = iv_nonce;
                  blk_d   = '0;
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (s.ct_valid) begin
               ct_d         = s.ct_data;
               core_start_c = 1'b1;
               state_d      = ST_CORE;
            end
         end
         ST_CORE: begin
            if (core_done_c) begin
               case (mode_q)
                  MODE_CBC: pt_data_d = core_dout_c ^ chain_q;
                  MODE_CTR: pt_data_d = core_dout_c ^ ct_q;
                  default:  pt_data_d = core_dout_c;
               endcase
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (s.pt_ready) begin
               chain_d = ct_q;
               blk_d   = blk_q + CNT_W'(1);
               ctr_d   = ctr_q + BLOCK_SIZE'(1);
               state_d = is_last_c ? ST_FIN : ST_LOAD;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered as a decode of the next state.
      ct_ready_d = (state_d == ST_LOAD);
      pt_valid_d = (state_d == ST_OUT);
      pt_last_d  = (state_d == ST_OUT) && is_last_c;
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_FIN) || (state_d == ST_ERR);
      error_d    = (state_d == ST_ERR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         mode_q     <= '0;
         key_q      <= '0;
         chain_q    <= '0;
         ctr_q      <= '0;
         ct_q       <= '0;
         nblk_q     <= '0;
         blk_q      <= '0;
         pt_data_q  <= '0;
         pt_last_q  <= 1'b0;
         pt_valid_q <= 1'b0;
         ct_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         key_q      <= key_d;
         chain_q    <= chain_d;
         ctr_q      <= ctr_d;
         ct_q       <= ct_d;
         nblk_q     <= nblk_d;
         blk_q      <= blk_d;
         pt_data_q  <= pt_data_d;
         pt_last_q  <= pt_last_d;
         pt_valid_q <= pt_valid_d;
         ct_ready_q <= ct_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign s.ct_ready = ct_ready_q;
   assign s.pt_valid = pt_valid_q;
   assign s.pt_data  = pt_data_q;
   assign s.pt_last  = pt_last_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_crypto_decrypt_stream.sv
// Directed bench for crypto_decrypt_stream: ciphertext is built by a local
// forward-cipher model, and every recovered block must equal its plaintext.
module tb_crypto_decrypt_stream;

   localparam int R = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start1;
   logic [1:0]  mode;
   logic [63:0] key, iv;
   logic [15:0] nblk;
   logic        busy, done, error;
   logic        busy1, done1, error1;

   int vectors     = 0;
   int miscompares = 0;

   crypto_decrypt_stream_if sif ();
   crypto_decrypt_stream_if sif1 ();

   crypto_decrypt_stream #(.ROUNDS(R), .CNT_W(16)) dut (
      .clk(clk), .reset(rst_n), .start(start), .mode(mode), .key(key),
      .iv_nonce(iv), .num_blocks(nblk), .s(sif),
      .busy(busy), .done(done), .error(error)
   );

   crypto_decrypt_stream #(.ROUNDS(1), .CNT_W(16)) dut1 (
      .clk(clk), .reset(rst_n), .start(start1), .mode(mode), .key(key),
      .iv_nonce(iv), .num_blocks(nblk), .s(sif1),
      .busy(busy1), .done(done1), .error(error1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rotl3(input logic [31:0] x);
      return (x << 3) | (x >> 29);
   endfunction

   // Forward cipher used to manufacture ciphertext and CTR keystream.
   function automatic logic [63:0] enc(input logic [63:0] k, input logic [63:0] b, input int rounds);
      logic [31:0] l, r, t, rk;
      l = b[63:32];
      r = b[31:0];
      for (int i = 0; i < rounds; i++) begin
         rk = ((i % 2 == 0) ? k[63:32] : k[31:0]) ^ 32'(i);
         t  = l ^ (rotl3(r) ^ (r + rk));
         l  = r;
         r  = t;
      end
      return {l, r};
   endfunction

   task automatic request(input logic [1:0] m, input logic [63:0] k, input logic [63:0] v,
                          input logic [15:0] n);
      mode = m; key = k; iv = v; nblk = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode = ~m; key = ~k; iv = ~v;
   endtask

   task automatic send_ct(input logic [63:0] c);
      int n;
      n = 0;
      sif.ct_valid = 1'b1;
      sif.ct_data  = c;
      while (sif.ct_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ct_ready_seen", 64'(sif.ct_ready), 64'd1);
      @(negedge clk);
      sif.ct_valid = 1'b0;
      sif.ct_data  = 64'hA5A5_A5A5_A5A5_A5A5;
      chk("ct_ready_after_hs", 64'(sif.ct_ready), 64'd0);
   endtask

   task automatic recv_pt(input logic [63:0] p, input logic last, input int stall, input int exp_lat);
      int n;
      n = 1;
      while (sif.pt_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("pt_latency", 64'(n), 64'(exp_lat));
      chk("pt_data", sif.pt_data, p);
      chk("pt_last", 64'(sif.pt_last), 64'(last));
      for (int s = 0; s < stall; s++) begin
         sif.pt_ready = 1'b0;
         @(negedge clk);
         chk("stall_pt_valid", 64'(sif.pt_valid), 64'd1);
         chk("stall_pt_data", sif.pt_data, p);
         chk("stall_pt_last", 64'(sif.pt_last), 64'(last));
         chk("stall_ct_ready", 64'(sif.ct_ready), 64'd0);
      end
      sif.pt_ready = 1'b1;
      @(negedge clk);
      sif.pt_ready = 1'b0;
   endtask

   task automatic chk_fin();
      chk("fin_done", 64'(done), 64'd1);
      chk("fin_error", 64'(error), 64'd0);
      @(negedge clk);
      chk("fin_done_clear", 64'(done), 64'd0);
      chk("fin_busy_clear", 64'(busy), 64'd0);
   endtask

   initial begin
      logic [63:0] p [4];
      logic [63:0] c [4];
      logic [63:0] prev, k;

      rst_n = 1'b0; start = 1'b0; start1 = 1'b0; mode = 2'b00;
      key = '0; iv = '0; nblk = '0;
      sif.ct_valid = 1'b0; sif.ct_data = '0; sif.pt_ready = 1'b0;
      sif1.ct_valid = 1'b0; sif1.ct_data = '0; sif1.pt_ready = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_ct_ready", 64'(sif.ct_ready), 64'd0);
      chk("rst_pt_valid", 64'(sif.pt_valid), 64'd0);
      chk("rst_pt_data", sif.pt_data, 64'd0);
      chk("rst_pt_last", 64'(sif.pt_last), 64'd0);
      chk("rst_busy_done_error", {61'd0, busy, done, error}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ECB, four blocks back to back
      k = 64'h0123_4567_89AB_CDEF;
      p[0] = 64'h0011_2233_4455_6677; p[1] = 64'hDEAD_BEEF_CAFE_F00D;
      p[2] = 64'h0000_0000_0000_0000; p[3] = 64'hFFFF_FFFF_FFFF_FFFF;
      request(2'b00, k, 64'd0, 16'd4);
      chk("ecb_busy", 64'(busy), 64'd1);
      for (int j = 0; j < 4; j++) begin
         send_ct(enc(k, p[j], R));
         recv_pt(p[j], (j == 3), 0, R + 1);
      end
      chk_fin();

      // CBC with a long stall on the middle block
      k = 64'h1357_9BDF_2468_ACE0;
      p[0] = 64'h1111_2222_3333_4444; p[1] = 64'h5555_6666_7777_8888; p[2] = 64'h0F0F_F0F0_1234_5678;
      prev = 64'hFFFF_0000_FFFF_0000;
      for (int j = 0; j < 3; j++) begin
         c[j] = enc(k, p[j] ^ prev, R);
         prev = c[j];
      end
      request(2'b01, k, 64'hFFFF_0000_FFFF_0000, 16'd3);
      for (int j = 0; j < 3; j++) begin
         send_ct(c[j]);
         recv_pt(p[j], (j == 2), (j == 1) ? 10 : 0, R + 1);
      end
      chk_fin();

      // CTR whose counter wraps to zero on the second block
      k = 64'hA5A5_0F0F_5A5A_F0F0;
      p[0] = 64'h0102_0304_0506_0708; p[1] = 64'h8877_6655_4433_2211;
      c[0] = p[0] ^ enc(k, 64'hFFFF_FFFF_FFFF_FFFF, R);
      c[1] = p[1] ^ enc(k, 64'h0000_0000_0000_0000, R);
      request(2'b10, k, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2);
      for (int j = 0; j < 2; j++) begin
         send_ct(c[j]);
         recv_pt(p[j], (j == 1), 0, R + 1);
      end
      chk_fin();

      // Illegal mode, then zero-length message
      for (int t = 0; t < 2; t++) begin
         if (t == 0) request(2'b11, 64'd5, 64'd0, 16'd2);
         else        request(2'b00, 64'd5, 64'd0, 16'd0);
         chk("err_done", 64'(done), 64'd1);
         chk("err_error", 64'(error), 64'd1);
         chk("err_ct_ready", 64'(sif.ct_ready), 64'd0);
         @(negedge clk);
         chk("err_pulse_end", {61'd0, done, error, sif.ct_ready}, 64'd0);
         chk("err_idle", 64'(busy), 64'd0);
      end

      // Asynchronous reset in the middle of the second block
      k = 64'h0123_4567_89AB_CDEF;
      p[0] = 64'h7766_5544_3322_1100; p[1] = 64'h0BAD_F00D_DEAD_C0DE;
      request(2'b00, k, 64'd0, 16'd2);
      send_ct(enc(k, p[0], R));
      recv_pt(p[0], 1'b0, 0, R + 1);
      send_ct(enc(k, p[1], R));
      repeat (5) @(negedge clk);
      chk("mid_core_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ct_ready", 64'(sif.ct_ready), 64'd0);
      chk("arst_pt_valid", 64'(sif.pt_valid), 64'd0);
      chk("arst_pt_data", sif.pt_data, 64'd0);
      chk("arst_pt_last", 64'(sif.pt_last), 64'd0);
      chk("arst_busy_done_error", {61'd0, busy, done, error}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_quiet", {61'd0, busy, done, error}, 64'd0);

      // Fresh ECB message; a start pulse while busy must be ignored
      k = 64'hFEDC_BA98_7654_3210;
      p[0] = 64'h0123_0123_4567_4567;
      request(2'b00, k, 64'd0, 16'd1);
      send_ct(enc(k, p[0], R));
      mode = 2'b11; nblk = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      recv_pt(p[0], 1'b1, 0, R);
      chk_fin();

      // Single-round core: CTR with zero key and nonce has an all-zero keystream
      mode = 2'b10; key = '0; iv = '0; nblk = 16'd1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      sif1.ct_valid = 1'b1;
      sif1.ct_data  = 64'hDEAD_BEEF_0000_0000;
      for (int n = 0; n < 20 && sif1.ct_ready !== 1'b1; n++) @(negedge clk);
      chk("r1_ct_ready", 64'(sif1.ct_ready), 64'd1);
      @(negedge clk);
      sif1.ct_valid = 1'b0;
      @(negedge clk);
      chk("r1_pt_valid", 64'(sif1.pt_valid), 64'd1);
      chk("r1_pt_data", sif1.pt_data, 64'hDEAD_BEEF_0000_0000);
      chk("r1_pt_last", 64'(sif1.pt_last), 64'd1);
      sif1.pt_ready = 1'b1;
      @(negedge clk);
      sif1.pt_ready = 1'b0;
      chk("r1_done", {62'd0, done1, error1}, 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
